// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA column/row/sync sequencer that starts and stops on whole-frame boundaries.
// Ports: clk, reset (async, active-high), pixel_ce (advance enable), run (frame request level),
//        column/row (current pixel), visible, hsync/vsync (active-low), line_start/frame_start
//        (one-clk pulses), busy (RUN or STOPPING).
// Optional: define VGA_TIMING_FRAME_CNT_EN to add frame_count, a 16-bit count of frame_start pulses.
module vga_timing_ctrl #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int H_WHOLE_LINE  = 800,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int V_WHOLE_FRAME = 525,
    localparam int COLUMN_BITS  = $clog2(H_WHOLE_LINE),
    localparam int ROW_BITS     = $clog2(V_WHOLE_FRAME)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_ce,
    input  logic                   run,
    output logic [COLUMN_BITS-1:0] column,
    output logic [ROW_BITS-1:0]    row,
    output logic                   visible,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   line_start,
    output logic                   frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]            frame_count,
`endif
    output logic                   busy
);
    // Wrap points come from the porch sum; H_WHOLE_LINE/V_WHOLE_FRAME only size the counters.
    localparam logic [COLUMN_BITS-1:0] H_LAST = COLUMN_BITS'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH - 1);
    localparam logic [ROW_BITS-1:0]    V_LAST = ROW_BITS'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH - 1);
    localparam logic [COLUMN_BITS-1:0] H_VIS  = COLUMN_BITS'(H_VISIBLE);
    localparam logic [ROW_BITS-1:0]    V_VIS  = ROW_BITS'(V_VISIBLE);
    localparam logic [COLUMN_BITS-1:0] HS_BEG = COLUMN_BITS'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [COLUMN_BITS-1:0] HS_END = COLUMN_BITS'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [ROW_BITS-1:0]    VS_BEG = ROW_BITS'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [ROW_BITS-1:0]    VS_END = ROW_BITS'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t                 state_q, state_d;
    logic [COLUMN_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0]    row_q, row_d;
    logic                   vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
    logic                   ls_q, ls_d, fs_q, fs_d, busy_q, busy_d;
    logic                   idle, h_wrap, f_wrap;

    // Next state and next counters; every registered output is derived from the _d values
    // so syncs, visible and coordinates stay aligned.
    always_comb begin
        idle    = state_q == IDLE;
        h_wrap  = col_q == H_LAST;
        f_wrap  = h_wrap && row_q == V_LAST;
        col_d   = (idle || h_wrap) ? '0 : col_q + COLUMN_BITS'(1);
        row_d   = (idle || f_wrap) ? '0 : row_q + ROW_BITS'(h_wrap);
        // run is re-evaluated every advance; only the frame boundary may drop back to IDLE.
        state_d = run ? RUN : (idle || f_wrap) ? IDLE : STOPPING;
        fs_d    = run && (idle || f_wrap);
        ls_d    = !idle && h_wrap && state_d != IDLE;
        busy_d  = state_d != IDLE;
        vis_d   = busy_d && col_d < H_VIS && row_d < V_VIS;
        hs_d    = !(col_d >= HS_BEG && col_d < HS_END);
        vs_d    = !(row_d >= VS_BEG && row_d < VS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            vis_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (pixel_ce) begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            vis_q   <= vis_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end else begin
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_q;

    // Counts the registered pulse, so the count for a frame appears the clock after its frame_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fc_q <= '0;
        else if (fs_q)
            fc_q <= fc_q + 16'd1;
    end

    assign frame_count = fc_q;
`endif

    assign column      = col_q;
    assign row         = row_q;
    assign visible     = vis_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: self-checking bench for vga_timing_ctrl on a reduced 16x11 raster.
module tb_vga_timing_ctrl;
    localparam int HW = 16, VW = 11, FR = HW * VW;

    logic clk = 1'b0, reset = 1'b0, pixel_ce = 1'b0, run = 1'b0;
    logic [3:0] column, row;
    logic visible, hsync, vsync, line_start, frame_start, busy;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3), .H_WHOLE_LINE(HW),
        .V_VISIBLE(6), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2), .V_WHOLE_FRAME(VW)
    ) dut (
        .clk(clk), .reset(reset), .pixel_ce(pixel_ce), .run(run),
        .column(column), .row(row), .visible(visible), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_count(frame_count),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] r;
        logic vis, hs, vs, ls, fs, bz;
`ifdef VGA_TIMING_FRAME_CNT_EN
        logic [15:0] fc;
`endif
    } obs_t;

    typedef struct {
        int n;
        int duty;
        bit run;
        int exp_fs;
        bit exp_busy;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    int cnt_vis, cnt_hs, cnt_vs, cnt_ls, cnt_fs, first_hs_col, first_vs_row;
    int m_p;
    bit m_busy, m_ls, m_fs;
    logic [15:0] m_fc;
    obs_t sb[$];
    vec_t tbl[11];

    // Reference model: a single linear pixel index m_p = row*HW + column.
    task automatic model();
        if (reset) begin
            m_p = 0; m_busy = 0; m_ls = 0; m_fs = 0; m_fc = '0;
        end else begin
            m_fc = m_fc + 16'(m_fs);
            m_ls = 0;
            if (pixel_ce && !m_busy) begin
                m_fs = run;
                m_busy = run;
                m_p = 0;
            end else if (pixel_ce) begin
                m_p = (m_p + 1) % FR;
                m_fs = 0;
                if (m_p == 0 && !run) m_busy = 0;
                else begin
                    m_ls = (m_p % HW) == 0;
                    m_fs = m_p == 0;
                end
            end else m_fs = 0;
        end
    endtask

    function automatic obs_t expect_now();
        obs_t e;
        int c = m_p % HW, r = m_p / HW;
        e.c = 4'(c); e.r = 4'(r);
        e.vis = m_busy && c < 8 && r < 6;
        e.hs = !(c >= 10 && c < 13);
        e.vs = !(r >= 7 && r < 9);
        e.ls = m_ls; e.fs = m_fs; e.bz = m_busy;
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc = m_fc;
`endif
        return e;
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a.c = column; a.r = row; a.vis = visible; a.hs = hsync; a.vs = vsync;
        a.ls = line_start; a.fs = frame_start; a.bz = busy;
`ifdef VGA_TIMING_FRAME_CNT_EN
        a.fc = frame_count;
`endif
        return a;
    endfunction

    function automatic obs_t reset_obs();
        obs_t e = '0;
        e.hs = 1'b1; e.vs = 1'b1;
        return e;
    endfunction

    task automatic check_obs(string name, obs_t a, obs_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got c=%0d r=%0d vis=%b hs=%b vs=%b ls=%b fs=%b bz=%b want c=%0d r=%0d vis=%b hs=%b vs=%b ls=%b fs=%b bz=%b (raw %h vs %h)",
                     name, $time, a.c, a.r, a.vis, a.hs, a.vs, a.ls, a.fs, a.bz,
                     e.c, e.r, e.vis, e.hs, e.vs, e.ls, e.fs, e.bz, a, e);
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_vis = 0; cnt_hs = 0; cnt_vs = 0; cnt_ls = 0; cnt_fs = 0;
        first_hs_col = -1; first_vs_row = -1;
    endtask

    // One clock: drive inputs, push the model's expectation at the edge, pop and compare 1 ns later.
    task automatic step(input bit ce_v, input bit run_v);
        pixel_ce = ce_v;
        run = run_v;
        @(posedge clk);
        model();
        sb.push_back(expect_now());
        #1;
        check_obs("cycle", actual(), sb.pop_front());
        cnt_vis += int'(visible);
        cnt_hs += int'(!hsync);
        cnt_vs += int'(!vsync);
        cnt_ls += int'(line_start);
        cnt_fs += int'(frame_start);
        if (!hsync && first_hs_col < 0) first_hs_col = int'(column);
        if (!vsync && first_vs_row < 0) first_vs_row = int'(row);
    endtask

    initial begin
        tbl[0]  = '{176, 1, 1'b1, 1, 1'b1};
        tbl[1]  = '{1,   1, 1'b1, 1, 1'b1};
        tbl[2]  = '{32,  1, 1'b1, 0, 1'b1};
        tbl[3]  = '{10,  1, 1'b0, 0, 1'b1};
        tbl[4]  = '{32,  1, 1'b0, 0, 1'b1};
        tbl[5]  = '{102, 1, 1'b1, 1, 1'b1};
        tbl[6]  = '{50,  1, 1'b0, 0, 1'b1};
        tbl[7]  = '{126, 1, 1'b0, 0, 1'b0};
        tbl[8]  = '{5,   1, 1'b0, 0, 1'b0};
        tbl[9]  = '{708, 4, 1'b1, 2, 1'b1};
        tbl[10] = '{704, 4, 1'b0, 0, 1'b0};

        #2 reset = 1'b1;
        #1 check_obs("reset_async", actual(), reset_obs());
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        // One whole frame from IDLE: structural counts independent of the model.
        clear_counts();
        for (int i = 0; i < FR; i++) step(1'b1, 1'b1);
        chk("frame_visible_cnt", cnt_vis, 48);
        chk("frame_hsync_low_cnt", cnt_hs, 33);
        chk("frame_vsync_low_cnt", cnt_vs, 32);
        chk("frame_line_start_cnt", cnt_ls, 10);
        chk("frame_start_cnt", cnt_fs, 1);
        chk("hsync_first_col", first_hs_col, 10);
        chk("vsync_first_row", first_vs_row, 7);
        step(1'b1, 1'b1);
        chk("wrap_frame_start", int'(frame_start), 1);
        chk("wrap_line_start", int'(line_start), 1);

        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;

        foreach (tbl[k]) begin
            clear_counts();
            for (int i = 0; i < tbl[k].n; i++) step((i % tbl[k].duty) == 0, tbl[k].run);
            chk($sformatf("seg%0d_frame_starts", k), cnt_fs, tbl[k].exp_fs);
            chk($sformatf("seg%0d_busy", k), int'(busy), int'(tbl[k].exp_busy));
        end

        // Asynchronous reset mid-frame, away from any clock edge.
        for (int i = 0; i < 101; i++) step(1'b1, 1'b1);
        chk("pre_reset_column", int'(column), 4);
        chk("pre_reset_row", int'(row), 6);
        #3 reset = 1'b1;
        #1 check_obs("reset_midframe", actual(), reset_obs());
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        reset = 1'b0;
        step(1'b1, 1'b1);
        chk("restart_frame_start", int'(frame_start), 1);
        chk("restart_column", int'(column), 0);

        clear_counts();
        for (int i = 0; i < 3 * FR; i++) step(1'b1, 1'b1);
        chk("fourth_frame_start", int'(frame_start), 1);
        chk("three_frame_pulses", cnt_fs, 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_count_at_4th", int'(frame_count), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
